// File: rtl/fd_de_pipe_regs.sv
// Fetch->Decode and Decode->Execute pipeline register bank.
// Applies the hazard unit's hold/bubble/advance controls to the FD and DE
// registers. Also keeps saturating stall and bubble counters for
// performance debug. Every output comes straight from a flop.

module fd_de_pipe_regs #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CTRL_W    = 12,
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,

    // hazard controls
    input  logic              stallD,
    input  logic              flushD,
    input  logic              flushE,

    // fetch side
    input  logic [XLEN-1:0]   PCF,
    input  logic [XLEN-1:0]   PCPlus4F,
    input  logic [31:0]       InstrF,

    // FD register outputs
    output logic [XLEN-1:0]   PCD,
    output logic [XLEN-1:0]   PCPlus4D,
    output logic [31:0]       InstrD,
    output logic              validD,

    // decode side
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdD,

    // DE register outputs
    output logic [CTRL_W-1:0] ctrlE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic              validE,

    // performance counters
    output logic [CNT_W-1:0]  stallCnt,
    output logic [CNT_W-1:0]  bubbleCnt
);

    // ------------------------------------------------------------------
    // FD register state
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   r_pc_d;
    logic [XLEN-1:0]   r_pc_plus4_d;
    logic [31:0]       r_instr_d;
    logic              r_valid_d;

    // ------------------------------------------------------------------
    // DE register state
    // ------------------------------------------------------------------
    logic [CTRL_W-1:0] r_ctrl_e;
    logic [XLEN-1:0]   r_rd1_e;
    logic [XLEN-1:0]   r_rd2_e;
    logic [XLEN-1:0]   r_imm_ext_e;
    logic [XLEN-1:0]   r_pc_e;
    logic [XLEN-1:0]   r_pc_plus4_e;
    logic [4:0]        r_rs1_e;
    logic [4:0]        r_rs2_e;
    logic [4:0]        r_rd_e;
    logic              r_valid_e;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic              w_stall_sat;
    logic              w_bubble_sat;

    // Saturation detect: counter is all ones.
    always_comb begin
        w_stall_sat  = &r_stall_cnt;
        w_bubble_sat = &r_bubble_cnt;
    end

    // FD register: flush beats stall, and stall beats advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_instr_d    <= NOP_INSTR;
            r_valid_d    <= 1'b0;
        end else if (flushD) begin
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_instr_d    <= NOP_INSTR;
            r_valid_d    <= 1'b0;
        end else if (!stallD) begin
            r_pc_d       <= PCF;
            r_pc_plus4_d <= PCPlus4F;
            r_instr_d    <= InstrF;
            r_valid_d    <= 1'b1;
        end
    end

    // DE register: a bubble is fully zeroed so that a zero RdE and a zero
    // regWrite can never produce a forwarding match. There is no hold
    // path because a load-use stall always comes with flushE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl_e     <= '0;
            r_rd1_e      <= '0;
            r_rd2_e      <= '0;
            r_imm_ext_e  <= '0;
            r_pc_e       <= '0;
            r_pc_plus4_e <= '0;
            r_rs1_e      <= '0;
            r_rs2_e      <= '0;
            r_rd_e       <= '0;
            r_valid_e    <= 1'b0;
        end else if (flushE) begin
            r_ctrl_e     <= '0;
            r_rd1_e      <= '0;
            r_rd2_e      <= '0;
            r_imm_ext_e  <= '0;
            r_pc_e       <= '0;
            r_pc_plus4_e <= '0;
            r_rs1_e      <= '0;
            r_rs2_e      <= '0;
            r_rd_e       <= '0;
            r_valid_e    <= 1'b0;
        end else begin
            r_ctrl_e     <= ctrlD;
            r_rd1_e      <= RD1D;
            r_rd2_e      <= RD2D;
            r_imm_ext_e  <= ImmExtD;
            r_pc_e       <= r_pc_d;
            r_pc_plus4_e <= r_pc_plus4_d;
            r_rs1_e      <= Rs1D;
            r_rs2_e      <= Rs2D;
            r_rd_e       <= RdD;
            r_valid_e    <= r_valid_d;
        end
    end

    // Stall counter: counts edges with stallD high and sticks at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stallD && !w_stall_sat) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Bubble counter: counts edges with flushE high and sticks at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (flushE && !w_bubble_sat) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    // Outputs are driven directly by the registers.
    always_comb begin
        PCD       = r_pc_d;
        PCPlus4D  = r_pc_plus4_d;
        InstrD    = r_instr_d;
        validD    = r_valid_d;
        ctrlE     = r_ctrl_e;
        RD1E      = r_rd1_e;
        RD2E      = r_rd2_e;
        ImmExtE   = r_imm_ext_e;
        PCE       = r_pc_e;
        PCPlus4E  = r_pc_plus4_e;
        Rs1E      = r_rs1_e;
        Rs2E      = r_rs2_e;
        RdE       = r_rd_e;
        validE    = r_valid_e;
        stallCnt  = r_stall_cnt;
        bubbleCnt = r_bubble_cnt;
    end

endmodule

// File: tb/tb_fd_de_pipe_regs.sv
// Bench for fd_de_pipe_regs: directed hazard scenarios followed by random
// stimulus, compared every cycle against a transaction-level model. A second
// instance with 4-bit counters exercises saturation.

module tb_fd_de_pipe_regs;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        stallD, flushD, flushE;
    logic [31:0] PCF, PCPlus4F, InstrF;
    logic [11:0] ctrlD;
    logic [31:0] RD1D, RD2D, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;

    logic [31:0] PCD, PCPlus4D, InstrD;
    logic        validD;
    logic [11:0] ctrlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        validE;
    logic [15:0] stallCnt, bubbleCnt;

    logic [31:0] s_PCD, s_PCPlus4D, s_InstrD;
    logic        s_validD;
    logic [11:0] s_ctrlE;
    logic [31:0] s_RD1E, s_RD2E, s_ImmExtE, s_PCE, s_PCPlus4E;
    logic [4:0]  s_Rs1E, s_Rs2E, s_RdE;
    logic        s_validE;
    logic [3:0]  s_stallCnt, s_bubbleCnt;

    fd_de_pipe_regs dut (
        .clk(clk), .rst_n(rst_n), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrF(InstrF),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .InstrD(InstrD), .validD(validD),
        .ctrlD(ctrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ctrlE(ctrlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .validE(validE), .stallCnt(stallCnt), .bubbleCnt(bubbleCnt)
    );

    fd_de_pipe_regs #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrF(InstrF),
        .PCD(s_PCD), .PCPlus4D(s_PCPlus4D), .InstrD(s_InstrD), .validD(s_validD),
        .ctrlD(ctrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ctrlE(s_ctrlE), .RD1E(s_RD1E), .RD2E(s_RD2E), .ImmExtE(s_ImmExtE),
        .PCE(s_PCE), .PCPlus4E(s_PCPlus4E), .Rs1E(s_Rs1E), .Rs2E(s_Rs2E), .RdE(s_RdE),
        .validE(s_validE), .stallCnt(s_stallCnt), .bubbleCnt(s_bubbleCnt)
    );

    // Reference model: one record per pipeline slot plus plain event counts.
    typedef struct {
        logic [31:0] pc, pc4, instr;
        logic        valid;
    } fd_t;

    typedef struct {
        logic [11:0] ctrl;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic        valid;
    } de_t;

    fd_t         m_fd;
    de_t         m_de;
    int unsigned m_stalls, m_bubbles;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned n, input int unsigned max);
        return (n > max) ? max : n;
    endfunction

    task automatic model_reset();
        m_fd = '{pc: 32'h0, pc4: 32'h0, instr: NOP, valid: 1'b0};
        m_de = '{ctrl: '0, rd1: '0, rd2: '0, imm: '0, pc: '0, pc4: '0,
                 rs1: '0, rs2: '0, rd: '0, valid: 1'b0};
        m_stalls  = 0;
        m_bubbles = 0;
    endtask

    // Apply one clock edge's worth of hazard rules to the model.
    task automatic model_edge();
        de_t nde;
        if (flushE) begin
            nde = '{ctrl: '0, rd1: '0, rd2: '0, imm: '0, pc: '0, pc4: '0,
                    rs1: '0, rs2: '0, rd: '0, valid: 1'b0};
        end else begin
            nde = '{ctrl: ctrlD, rd1: RD1D, rd2: RD2D, imm: ImmExtD, pc: m_fd.pc,
                    pc4: m_fd.pc4, rs1: Rs1D, rs2: Rs2D, rd: RdD, valid: m_fd.valid};
        end
        if (flushD)
            m_fd = '{pc: 32'h0, pc4: 32'h0, instr: NOP, valid: 1'b0};
        else if (!stallD)
            m_fd = '{pc: PCF, pc4: PCPlus4F, instr: InstrF, valid: 1'b1};
        m_de = nde;
        if (stallD) m_stalls++;
        if (flushE) m_bubbles++;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".PCD"},       PCD,       m_fd.pc);
        check({tag, ".PCPlus4D"},  PCPlus4D,  m_fd.pc4);
        check({tag, ".InstrD"},    InstrD,    m_fd.instr);
        check({tag, ".validD"},    validD,    m_fd.valid);
        check({tag, ".ctrlE"},     ctrlE,     m_de.ctrl);
        check({tag, ".RD1E"},      RD1E,      m_de.rd1);
        check({tag, ".RD2E"},      RD2E,      m_de.rd2);
        check({tag, ".ImmExtE"},   ImmExtE,   m_de.imm);
        check({tag, ".PCE"},       PCE,       m_de.pc);
        check({tag, ".PCPlus4E"},  PCPlus4E,  m_de.pc4);
        check({tag, ".Rs1E"},      Rs1E,      m_de.rs1);
        check({tag, ".Rs2E"},      Rs2E,      m_de.rs2);
        check({tag, ".RdE"},       RdE,       m_de.rd);
        check({tag, ".validE"},    validE,    m_de.valid);
        check({tag, ".stallCnt"},  stallCnt,  sat(m_stalls, 65535));
        check({tag, ".bubbleCnt"}, bubbleCnt, sat(m_bubbles, 65535));
        check({tag, ".s_InstrD"},  s_InstrD,  m_fd.instr);
        check({tag, ".s_RdE"},     s_RdE,     m_de.rd);
        check({tag, ".s_stallCnt"},  s_stallCnt,  sat(m_stalls, 15));
        check({tag, ".s_bubbleCnt"}, s_bubbleCnt, sat(m_bubbles, 15));
    endtask

    // Called at a falling edge with inputs already set; returns at the next
    // falling edge after checking.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic set_fetch(input logic [31:0] pc, input logic [31:0] instr);
        PCF      = pc;
        PCPlus4F = pc + 32'd4;
        InstrF   = instr;
    endtask

    task automatic rand_decode();
        ctrlD   = 12'($urandom);
        RD1D    = $urandom;
        RD2D    = $urandom;
        ImmExtD = $urandom;
        Rs1D    = 5'($urandom);
        Rs2D    = 5'($urandom);
        RdD     = 5'($urandom_range(1, 31));
    endtask

    task automatic ctl(input logic s, input logic fd, input logic fe);
        stallD = s;
        flushD = fd;
        flushE = fe;
    endtask

    initial begin
        ctl(1'b0, 1'b0, 1'b0);
        set_fetch(32'h0, 32'h0);
        rand_decode();
        model_reset();
        repeat (2) @(negedge clk);
        check_all("por");
        rst_n = 1'b1;

        // Free-run three instructions.
        set_fetch(32'h0, 32'h00100093); rand_decode(); step("run0");
        check("run0.InstrD", InstrD, 32'h00100093);
        set_fetch(32'h4, 32'h00200113); rand_decode(); step("run1");
        set_fetch(32'h8, 32'h00412083); rand_decode(); step("run2");
        check("run2.validE", validE, 1'b1);
        check("run2.PCE", PCE, 32'h4);

        // Load-use: FD holds, DE bubbles.
        set_fetch(32'hC, 32'h00500193); rand_decode();
        ctl(1'b1, 1'b0, 1'b1); step("lu");
        check("lu.InstrD", InstrD, 32'h00412083);
        check("lu.PCD", PCD, 32'h8);
        check("lu.RdE", RdE, 5'd0);
        check("lu.validE", validE, 1'b0);
        check("lu.stallCnt", stallCnt, 16'd1);
        check("lu.bubbleCnt", bubbleCnt, 16'd1);
        ctl(1'b0, 1'b0, 1'b0); rand_decode(); step("lu_resume");
        check("lu_resume.validE", validE, 1'b1);

        // Branch redirect: both stages bubble together.
        set_fetch(32'h10, 32'h00600213); rand_decode();
        ctl(1'b0, 1'b1, 1'b1); step("br");
        check("br.InstrD", InstrD, NOP);
        check("br.validD", validD, 1'b0);
        check("br.bubbleCnt", bubbleCnt, 16'd2);
        set_fetch(32'h40, 32'h00700293); rand_decode();
        ctl(1'b0, 1'b0, 1'b0); step("br1");
        check("br1.validE", validE, 1'b0);

        // Flush outranks stall on FD; nonzero ctrl still gives validE=0.
        ctl(1'b1, 1'b1, 1'b0); rand_decode(); step("prio");
        check("prio.validD", validD, 1'b0);
        check("prio.InstrD", InstrD, NOP);
        ctl(1'b0, 1'b0, 1'b0); ctrlD = 12'hFFF; step("prio1");
        check("prio1.validE", validE, 1'b0);
        check("prio1.ctrlE", ctrlE, 12'hFFF);

        // Reset mid-cycle with a full pipeline: clears without an edge.
        set_fetch(32'h80, 32'h00800313); rand_decode(); step("fill");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("arst");
        check("arst.InstrD", InstrD, NOP);
        check("arst.stallCnt", stallCnt, 16'd0);
        @(negedge clk);
        check_all("arst_hold");
        rst_n = 1'b1;

        // Saturation on the 4-bit counters.
        ctl(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            rand_decode();
            step("sat");
        end
        check("sat.s_stallCnt", s_stallCnt, 4'd15);
        check("sat.stallCnt", stallCnt, 16'd20);

        // Random traffic with an occasional asynchronous reset.
        for (int i = 0; i < 400; i++) begin
            set_fetch($urandom, $urandom);
            rand_decode();
            ctl($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                $urandom_range(0, 4) == 0);
            if (i == 200) begin
                #3 rst_n = 1'b0;
                #1 model_reset();
                check_all("rnd_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
